// File: rtl/br_pkg.sv
// Branch-resolution constants and predictor types shared by the checkpoint
// buffer and the direction predictor.
package br_pkg;

    localparam int unsigned BHR_W_DEF = 8;

    localparam logic [1:0] BR_NONE       = 2'b00;
    localparam logic [1:0] BR_PR_CORRECT = 2'b01;
    localparam logic [1:0] BR_PR_WRONG   = 2'b10;

    // 2-bit saturating PHT counter state
    typedef enum logic [1:0] {
        P_SNT = 2'b00,
        P_WNT = 2'b01,
        P_WT  = 2'b10,
        P_ST  = 2'b11
    } p_state_t;

endpackage

// File: rtl/ckpt_ptr.sv
// Head/tail pointers with wrap bit for the BHR checkpoint ring: occupancy,
// tag liveness and the tail value that a mispredict flush restores.
module ckpt_ptr #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned TAG_W = $clog2(DEPTH),
    localparam int unsigned PTR_W = TAG_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc,
    input  logic             retire,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tag,
    input  logic [TAG_W-1:0] chk_tag,
    output logic [TAG_W-1:0] head_idx,
    output logic [TAG_W-1:0] tail_idx,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count,
    output logic             tag_live
);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] flush_tail;
    logic [TAG_W-1:0] chk_off;
    logic             flush_wrap;

    always_comb begin
        head_idx   = head[TAG_W-1:0];
        tail_idx   = tail[TAG_W-1:0];
        full       = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);
        empty      = (head == tail);
        count      = tail - head;
        // a tag is live when its distance from head is below the occupancy
        chk_off    = chk_tag - head_idx;
        tag_live   = ({1'b0, chk_off} < count);
        // tags below head's index belong to the next lap of the ring
        flush_wrap = (flush_tag >= head_idx) ? head[TAG_W] : ~head[TAG_W];
        flush_tail = {flush_wrap, flush_tag} + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (retire) begin
                head <= head + PTR_W'(1);
            end
            if (flush) begin
                tail <= flush_tail;
            end else if (alloc) begin
                tail <= tail + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/bhr_ckpt_buf.sv
// Checkpoint buffer for the global BHR: snapshots per in-flight branch, PHT
// update on resolution, BHR repair and younger-entry flush on mispredict.
module bhr_ckpt_buf
    import br_pkg::*;
#(
    parameter  int unsigned BHR_W = BHR_W_DEF,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_i,
    input  logic [BHR_W-1:0] alloc_bhr_i,
    output logic             alloc_rdy_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic [1:0]       reslv_i,
    input  logic [TAG_W-1:0] reslv_tag_i,
    input  logic             reslv_taken_i,
    output logic             upd_vld_o,
    output logic [BHR_W-1:0] upd_idx_o,
    output logic             upd_taken_o,
    output logic             recov_vld_o,
    output logic [BHR_W-1:0] recov_bhr_o,
    output logic [TAG_W:0]   count_o
);

    logic [BHR_W-1:0] bhr_mem [DEPTH];
    logic [DEPTH-1:0] done;
    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic [BHR_W-1:0] res_bhr;
    logic             full;
    logic             empty;
    logic             tag_live;
    logic             res_vld;
    logic             flush;
    logic             alloc_ok;
    logic             retire;

    ckpt_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc     (alloc_ok),
        .retire    (retire),
        .flush     (flush),
        .flush_tag (reslv_tag_i),
        .chk_tag   (reslv_tag_i),
        .head_idx  (head_idx),
        .tail_idx  (tail_idx),
        .full      (full),
        .empty     (empty),
        .count     (count_o),
        .tag_live  (tag_live)
    );

    // the redirect that accompanies a flush makes a same-cycle alloc stale
    always_comb begin
        res_vld     = ((reslv_i == BR_PR_CORRECT) || (reslv_i == BR_PR_WRONG)) && tag_live;
        flush       = res_vld && (reslv_i == BR_PR_WRONG);
        alloc_ok    = alloc_i && !full && !flush;
        retire      = !empty && done[head_idx];
        res_bhr     = bhr_mem[reslv_tag_i];
        alloc_rdy_o = !full;
        alloc_tag_o = tail_idx;
    end

    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            bhr_mem[tail_idx] <= alloc_bhr_i;
        end
    end

    // alloc and resolve never target the same slot: a resolving tag is live, tail is not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= '0;
        end else begin
            if (alloc_ok) begin
                done[tail_idx] <= 1'b0;
            end
            if (res_vld) begin
                done[reslv_tag_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_vld_o   <= 1'b0;
            upd_idx_o   <= '0;
            upd_taken_o <= 1'b0;
            recov_vld_o <= 1'b0;
            recov_bhr_o <= '0;
        end else begin
            upd_vld_o   <= res_vld;
            recov_vld_o <= flush;
            if (res_vld) begin
                upd_idx_o   <= res_bhr;
                upd_taken_o <= reslv_taken_i;
            end
            if (flush) begin
                recov_bhr_o <= {res_bhr[BHR_W-2:0], reslv_taken_i};
            end
        end
    end

endmodule

// File: tb/tb_bhr_ckpt_buf.sv
// Directed bench for bhr_ckpt_buf: reset, fill, out-of-order resolve,
// mispredict flush, wrap-around and alloc/flush collision.
module tb_bhr_ckpt_buf;
    import br_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_i;
    logic [7:0] alloc_bhr_i;
    logic       alloc_rdy_o;
    logic [2:0] alloc_tag_o;
    logic [1:0] reslv_i;
    logic [2:0] reslv_tag_i;
    logic       reslv_taken_i;
    logic       upd_vld_o;
    logic [7:0] upd_idx_o;
    logic       upd_taken_o;
    logic       recov_vld_o;
    logic [7:0] recov_bhr_o;
    logic [3:0] count_o;

    int checks = 0;
    int errors = 0;

    bhr_ckpt_buf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_i       (alloc_i),
        .alloc_bhr_i   (alloc_bhr_i),
        .alloc_rdy_o   (alloc_rdy_o),
        .alloc_tag_o   (alloc_tag_o),
        .reslv_i       (reslv_i),
        .reslv_tag_i   (reslv_tag_i),
        .reslv_taken_i (reslv_taken_i),
        .upd_vld_o     (upd_vld_o),
        .upd_idx_o     (upd_idx_o),
        .upd_taken_o   (upd_taken_o),
        .recov_vld_o   (recov_vld_o),
        .recov_bhr_o   (recov_bhr_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_i       = 1'b0;
        alloc_bhr_i   = 8'h00;
        reslv_i       = BR_NONE;
        reslv_tag_i   = 3'd0;
        reslv_taken_i = 1'b0;
    endtask

    task automatic do_alloc(input logic [7:0] bhr);
        alloc_i     = 1'b1;
        alloc_bhr_i = bhr;
        tick();
        idle();
    endtask

    task automatic do_reslv(input logic [1:0] kind, input logic [2:0] tag, input logic taken);
        reslv_i       = kind;
        reslv_tag_i   = tag;
        reslv_taken_i = taken;
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_rdy", 32'(alloc_rdy_o), 32'd1);
        check("rst_tag", 32'(alloc_tag_o), 32'd0);
        check("rst_upd_vld", 32'(upd_vld_o), 32'd0);
        check("rst_recov_vld", 32'(recov_vld_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: async reset with 5 live entries and a pending update strobe
        for (int i = 0; i < 5; i++) do_alloc(8'h01 + 8'(i));
        check("t1_count5", 32'(count_o), 32'd5);
        do_reslv(BR_PR_CORRECT, 3'd1, 1'b1);
        check("t1_upd_vld", 32'(upd_vld_o), 32'd1);
        check("t1_upd_idx", 32'(upd_idx_o), 32'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_count", 32'(count_o), 32'd0);
        check("t1_async_rdy", 32'(alloc_rdy_o), 32'd1);
        check("t1_async_upd", 32'(upd_vld_o), 32'd0);
        check("t1_async_recov", 32'(recov_vld_o), 32'd0);
        check("t1_async_idx", 32'(upd_idx_o), 32'd0);
        #2;
        rst_n = 1'b1;

        // 2: fill to DEPTH, then an extra alloc is dropped
        for (int i = 0; i < 8; i++) begin
            alloc_i     = 1'b1;
            alloc_bhr_i = 8'h10 + 8'(i);
            #1;
            check("t2_tag", 32'(alloc_tag_o), 32'(i));
            check("t2_rdy", 32'(alloc_rdy_o), 32'd1);
            tick();
        end
        idle();
        check("t2_full_rdy", 32'(alloc_rdy_o), 32'd0);
        check("t2_full_count", 32'(count_o), 32'd8);
        do_alloc(8'h99);
        check("t2_over_count", 32'(count_o), 32'd8);
        check("t2_over_tag", 32'(alloc_tag_o), 32'd0);

        // 3: out-of-order correct resolutions; head waits for tag 0
        do_reslv(BR_PR_CORRECT, 3'd2, 1'b1);
        check("t3_upd_vld_a", 32'(upd_vld_o), 32'd1);
        check("t3_upd_idx_a", 32'(upd_idx_o), 32'h12);
        check("t3_upd_tkn_a", 32'(upd_taken_o), 32'd1);
        check("t3_recov_a", 32'(recov_vld_o), 32'd0);
        check("t3_count_a", 32'(count_o), 32'd8);
        do_reslv(BR_PR_CORRECT, 3'd0, 1'b1);
        check("t3_upd_vld_b", 32'(upd_vld_o), 32'd1);
        check("t3_upd_idx_b", 32'(upd_idx_o), 32'h10);
        check("t3_count_b", 32'(count_o), 32'd8);
        tick();
        check("t3_upd_pulse", 32'(upd_vld_o), 32'd0);
        check("t3_retire0", 32'(count_o), 32'd7);
        check("t3_rdy", 32'(alloc_rdy_o), 32'd1);
        tick();
        check("t3_stop_at1", 32'(count_o), 32'd7);

        // 4: mispredict flush of younger entries
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) do_alloc((i == 3) ? 8'h81 : 8'h20 + 8'(i));
        check("t4_count6", 32'(count_o), 32'd6);
        do_reslv(BR_PR_WRONG, 3'd3, 1'b1);
        check("t4_recov_vld", 32'(recov_vld_o), 32'd1);
        check("t4_recov_bhr", 32'(recov_bhr_o), 32'h03);
        check("t4_upd_idx", 32'(upd_idx_o), 32'h81);
        check("t4_count4", 32'(count_o), 32'd4);
        check("t4_next_tag", 32'(alloc_tag_o), 32'd4);
        tick();
        check("t4_recov_pulse", 32'(recov_vld_o), 32'd0);
        check("t4_upd_pulse", 32'(upd_vld_o), 32'd0);
        do_alloc(8'h77);
        check("t4_count5", 32'(count_o), 32'd5);
        check("t4_tag5", 32'(alloc_tag_o), 32'd5);

        // 5: wrap-around; retire 0..5 so head=6, then allocate 6,7,0,1
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) do_alloc(8'h30 + 8'(i));
        for (int i = 0; i < 6; i++) do_reslv(BR_PR_CORRECT, 3'(i), 1'b0);
        tick();
        check("t5_empty", 32'(count_o), 32'd0);
        check("t5_head6_tag", 32'(alloc_tag_o), 32'd6);
        for (int i = 0; i < 4; i++) do_alloc(8'h40 + 8'(i));
        check("t5_count4", 32'(count_o), 32'd4);
        check("t5_tail_tag", 32'(alloc_tag_o), 32'd2);
        do_reslv(BR_PR_WRONG, 3'd0, 1'b0);
        check("t5_wrap_count", 32'(count_o), 32'd3);
        check("t5_wrap_tag", 32'(alloc_tag_o), 32'd1);
        check("t5_recov_vld", 32'(recov_vld_o), 32'd1);
        check("t5_recov_bhr", 32'(recov_bhr_o), 32'h84);
        do_reslv(BR_PR_CORRECT, 3'd1, 1'b1);
        check("t5_dead_upd", 32'(upd_vld_o), 32'd0);
        check("t5_dead_count", 32'(count_o), 32'd3);

        // 6: alloc colliding with a flush is dropped; dead tag ignored
        alloc_i       = 1'b1;
        alloc_bhr_i   = 8'h55;
        reslv_i       = BR_PR_WRONG;
        reslv_tag_i   = 3'd7;
        reslv_taken_i = 1'b0;
        tick();
        idle();
        check("t6_coll_count", 32'(count_o), 32'd2);
        check("t6_coll_tag", 32'(alloc_tag_o), 32'd0);
        check("t6_coll_recov", 32'(recov_bhr_o), 32'h82);
        do_reslv(BR_PR_WRONG, 3'd0, 1'b1);
        check("t6_dead_upd", 32'(upd_vld_o), 32'd0);
        check("t6_dead_recov", 32'(recov_vld_o), 32'd0);
        check("t6_dead_count", 32'(count_o), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
